// File: rtl/alu_pkg.sv
// Shared types and encodings for the sequential ALU: FSM states, decoded
// operation codes, RV32 R-type funct3/funct7 constants and the decoder.
package alu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC1,
      S_SHIFT,
      S_MUL,
      S_DONE
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD,
      OP_SUB,
      OP_SLL,
      OP_SRL,
      OP_SRA,
      OP_SLT,
      OP_SLTU,
      OP_XOR,
      OP_OR,
      OP_AND,
      OP_MUL,
      OP_ILL
   } op_t;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // Map a funct3/funct7 pair onto an operation; mul_en gates MUL legality.
   function automatic op_t decode_op(input logic [2:0] f3, input logic [6:0] f7,
                                     input logic mul_en);
      op_t op;
      op = OP_ILL;
      case (f7)
         F7_BASE: begin
            case (f3)
               F3_ADD:  op = OP_ADD;
               F3_SLL:  op = OP_SLL;
               F3_SLT:  op = OP_SLT;
               F3_SLTU: op = OP_SLTU;
               F3_XOR:  op = OP_XOR;
               F3_SR:   op = OP_SRL;
               F3_OR:   op = OP_OR;
               default: op = OP_AND;
            endcase
         end
         F7_ALT: begin
            if (f3 == F3_ADD)     op = OP_SUB;
            else if (f3 == F3_SR) op = OP_SRA;
         end
         F7_MULDIV: begin
            if ((f3 == F3_ADD) && mul_en) op = OP_MUL;
         end
         default: op = OP_ILL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/cla_adder.sv
// Carry-lookahead adder: 4-bit lookahead groups, group carries ripple
// from one group to the next. WIDTH must be a multiple of 4.
module cla_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             ci_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             co_o
);

   localparam int unsigned NG = WIDTH / 4;

   logic [NG-1:0][3:0] g;
   logic [NG-1:0][3:0] p;
   logic [NG-1:0][3:0] s;
   logic [NG:0]        gc;

   assign g     = a_i & b_i;
   assign p     = a_i ^ b_i;
   assign gc[0] = ci_i;

   for (genvar k = 0; k < NG; k++) begin : g_grp
      logic [3:0] c;
      logic       cin;
      assign cin  = gc[k];
      assign c[0] = cin;
      assign c[1] = g[k][0] | (p[k][0] & cin);
      assign c[2] = g[k][1] | (p[k][1] & g[k][0]) | (p[k][1] & p[k][0] & cin);
      assign c[3] = g[k][2] | (p[k][2] & g[k][1]) | (p[k][2] & p[k][1] & g[k][0])
                  | (p[k][2] & p[k][1] & p[k][0] & cin);
      assign gc[k+1] = g[k][3] | (p[k][3] & g[k][2]) | (p[k][3] & p[k][2] & g[k][1])
                     | (p[k][3] & p[k][2] & p[k][1] & g[k][0]) | ((&p[k]) & cin);
      assign s[k] = p[k] ^ c;
   end

   assign sum_o = s;
   assign co_o  = gc[NG];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle RV32 R-type ALU with valid/ready handshakes on both sides.
// Shifts iterate one bit per cycle; the shift-add multiplier is compiled in
// only when ALU_SEQ_MUL_EN is defined, otherwise MUL decodes as illegal.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             iValid,
   output logic             oReady,
   input  logic [WIDTH-1:0] iDataA,
   input  logic [WIDTH-1:0] iDataB,
   input  logic [2:0]       iFunct3,
   input  logic [6:0]       iFunct7,
   output logic             oValid,
   input  logic             iReady,
   output logic [WIDTH-1:0] oData,
   output logic             oZero,
   output logic             oIllegal
);

`ifdef ALU_SEQ_MUL_EN
   localparam logic MUL_EN = 1'b1;
`else
   localparam logic MUL_EN = 1'b0;
`endif

   // Gate-level borrow-chain decrementer for the iteration counter.
   function automatic logic [SHW-1:0] dec_cnt(input logic [SHW-1:0] x);
      logic [SHW-1:0] r;
      logic           borrow;
      borrow = 1'b1;
      for (int unsigned i = 0; i < SHW; i++) begin
         r[i]   = x[i] ^ borrow;
         borrow = borrow & ~x[i];
      end
      return r;
   endfunction

   state_t           state_q, state_d;
   op_t              op_q, op_d, op_in;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, data_q, data_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             zero_q, zero_d, ill_q, ill_d;
`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0] acc_q, acc_d, mplier_q, mplier_d;
   logic             last_q, last_d;
`endif

   logic [WIDTH-1:0] add_a, add_b, add_sum, exec_res, sh_step;
   logic             add_ci, add_co, ovf, slt_bit, sltu_bit, exec_ill;

   assign op_in = decode_op(iFunct3, iFunct7, MUL_EN);

   // Adder operand selection: A+B, A+~B+1 for subtract/compare, acc+mcand in MUL.
   always_comb begin
      add_a  = a_q;
      add_b  = b_q;
      add_ci = 1'b0;
      if ((op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SLTU)) begin
         add_b  = ~b_q;
         add_ci = 1'b1;
      end
`ifdef ALU_SEQ_MUL_EN
      if (state_q == S_MUL) begin
         add_a  = acc_q;
         add_b  = sh_q;
         add_ci = 1'b0;
      end
`endif
   end

   cla_adder #(.WIDTH(WIDTH)) u_cla (
      .a_i   (add_a),
      .b_i   (add_b),
      .ci_i  (add_ci),
      .sum_o (add_sum),
      .co_o  (add_co)
   );

   assign ovf      = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ add_sum[WIDTH-1]);
   assign slt_bit  = add_sum[WIDTH-1] ^ ovf;
   assign sltu_bit = ~add_co;

   // Single-cycle result; shift ops only reach EXEC1 with a zero amount.
   always_comb begin
      exec_res = '0;
      exec_ill = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB:        exec_res = add_sum;
         OP_SLT:                exec_res[0] = slt_bit;
         OP_SLTU:               exec_res[0] = sltu_bit;
         OP_XOR:                exec_res = a_q ^ b_q;
         OP_OR:                 exec_res = a_q | b_q;
         OP_AND:                exec_res = a_q & b_q;
         OP_SLL, OP_SRL, OP_SRA: exec_res = a_q;
         default:               exec_ill = 1'b1;
      endcase
   end

   // One-bit shift step as a pure wire permutation.
   always_comb begin
      case (op_q)
         OP_SLL:  sh_step = {sh_q[WIDTH-2:0], 1'b0};
         OP_SRA:  sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
         default: sh_step = {1'b0, sh_q[WIDTH-1:1]};
      endcase
   end

   // Next-state, datapath and output-register update logic.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      zero_d  = zero_q;
      ill_d   = ill_q;
`ifdef ALU_SEQ_MUL_EN
      acc_d    = acc_q;
      mplier_d = mplier_q;
      last_d   = last_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (iValid) begin
               op_d    = op_in;
               a_d     = iDataA;
               b_d     = iDataB;
               sh_d    = iDataA;
               cnt_d   = '0;
               state_d = S_EXEC1;
               case (op_in)
                  OP_SLL, OP_SRL, OP_SRA: begin
                     if (iDataB[SHW-1:0] != '0) begin
                        state_d = S_SHIFT;
                        cnt_d   = iDataB[SHW-1:0];
                     end
                  end
`ifdef ALU_SEQ_MUL_EN
                  OP_MUL: begin
                     state_d  = S_MUL;
                     cnt_d    = '1;
                     acc_d    = '0;
                     mplier_d = iDataB;
                     last_d   = 1'b0;
                  end
`endif
                  default: ;
               endcase
            end
         end
         S_EXEC1: begin
            data_d  = exec_res;
            zero_d  = ~|exec_res;
            ill_d   = exec_ill;
            state_d = S_DONE;
         end
         S_SHIFT: begin
            if (cnt_q == '0) begin
               data_d  = sh_q;
               zero_d  = ~|sh_q;
               ill_d   = 1'b0;
               state_d = S_DONE;
            end else begin
               sh_d  = sh_step;
               cnt_d = dec_cnt(cnt_q);
            end
         end
`ifdef ALU_SEQ_MUL_EN
         // A SHW-bit counter cannot hold WIDTH, so a flag marks that the
         // final (count 0) iteration has run; the next cycle publishes acc.
         S_MUL: begin
            if (last_q) begin
               data_d  = acc_q;
               zero_d  = ~|acc_q;
               ill_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               if (mplier_q[0]) acc_d = add_sum;
               mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
               sh_d     = {sh_q[WIDTH-2:0], 1'b0};
               cnt_d    = dec_cnt(cnt_q);
               last_d   = (cnt_q == '0);
            end
         end
`endif
         S_DONE: begin
            if (iReady) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q <= S_IDLE;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         zero_q  <= 1'b1;
         ill_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= '0;
         mplier_q <= '0;
         last_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         ill_q   <= ill_d;
`ifdef ALU_SEQ_MUL_EN
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         last_q   <= last_d;
`endif
      end
   end

   assign oReady   = (state_q == S_IDLE);
   assign oValid   = (state_q == S_DONE);
   assign oData    = data_q;
   assign oZero    = zero_q;
   assign oIllegal = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results are queued when a request
// is driven and popped when the DUT raises oValid.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   logic         iClk, iRstN, iValid, oReady, oValid, iReady, oZero, oIllegal;
   logic [W-1:0] iDataA, iDataB, oData;
   logic [2:0]   iFunct3;
   logic [6:0]   iFunct7;

   alu_seq #(.WIDTH(W)) dut (
      .iClk     (iClk),
      .iRstN    (iRstN),
      .iValid   (iValid),
      .oReady   (oReady),
      .iDataA   (iDataA),
      .iDataB   (iDataB),
      .iFunct3  (iFunct3),
      .iFunct7  (iFunct7),
      .oValid   (oValid),
      .iReady   (iReady),
      .oData    (oData),
      .oZero    (oZero),
      .oIllegal (oIllegal)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   typedef struct {
      logic [W-1:0] data;
      logic         ill;
      int           lat;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input string name);
      exp_t        e;
      logic [4:0]  sh;
      sh     = b[4:0];
      e.name = name;
      e.data = '0;
      e.ill  = 1'b0;
      e.lat  = 1;
      case ({f7, f3})
         {F7_BASE, F3_ADD}:  e.data = a + b;
         {F7_ALT,  F3_ADD}:  e.data = a - b;
         {F7_BASE, F3_SLL}: begin e.data = a << sh; e.lat = (sh == 0) ? 1 : 1 + int'(sh); end
         {F7_BASE, F3_SR}:  begin e.data = a >> sh; e.lat = (sh == 0) ? 1 : 1 + int'(sh); end
         {F7_ALT,  F3_SR}:  begin e.data = $unsigned($signed(a) >>> sh); e.lat = (sh == 0) ? 1 : 1 + int'(sh); end
         {F7_BASE, F3_SLT}:  e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         {F7_BASE, F3_SLTU}: e.data = (a < b) ? 32'd1 : 32'd0;
         {F7_BASE, F3_XOR}:  e.data = a ^ b;
         {F7_BASE, F3_OR}:   e.data = a | b;
         {F7_BASE, F3_AND}:  e.data = a & b;
`ifdef ALU_SEQ_MUL_EN
         {F7_MULDIV, F3_ADD}: begin e.data = a * b; e.lat = W + 1; end
`endif
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   // Wait for oReady, present the request for exactly the accept edge, then scramble inputs.
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f3, input logic [6:0] f7, input string name);
      int t;
      t = 0;
      @(negedge iClk);
      while (!oReady && t < 100) begin
         @(negedge iClk);
         t++;
      end
      check({name, " ready"}, 64'(oReady), 64'd1);
      iDataA  = a;
      iDataB  = b;
      iFunct3 = f3;
      iFunct7 = f7;
      iValid  = 1'b1;
      @(posedge iClk);
      #1;
      iValid  = 1'b0;
      iDataA  = $urandom;
      iDataB  = $urandom;
      iFunct3 = 3'($urandom);
      iFunct7 = 7'($urandom);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f3, input logic [6:0] f7, input string name);
      sb.push_back(model(a, b, f3, f7, name));
      drive(a, b, f3, f7, name);
   endtask

   // Wait for the result, compare against the scoreboard, optionally hold
   // back-pressure (pulsing iValid meanwhile), then consume.
   task automatic collect(input int lat0, input int hold, input bit pulse);
      int           lat;
      exp_t         e;
      logic [W-1:0] d0;
      logic         z0, i0;
      lat = lat0;
      while (!oValid && lat < 200) begin
         @(posedge iClk);
         #1;
         lat++;
      end
      e = sb.pop_front();
      check({e.name, " valid"},   64'(oValid),   64'd1);
      check({e.name, " latency"}, 64'(lat),      64'(e.lat));
      check({e.name, " data"},    64'(oData),    64'(e.data));
      check({e.name, " zero"},    64'(oZero),    64'(e.data == '0));
      check({e.name, " illegal"}, 64'(oIllegal), 64'(e.ill));
      d0 = oData;
      z0 = oZero;
      i0 = oIllegal;
      for (int i = 0; i < hold; i++) begin
         if (pulse && i == 1) begin
            iDataA = 32'h1111_1111; iDataB = 32'h2222_2222;
            iFunct3 = F3_ADD; iFunct7 = F7_BASE; iValid = 1'b1;
         end
         @(posedge iClk);
         #1;
         iValid = 1'b0;
         check({e.name, " bp valid"}, 64'(oValid),                 64'd1);
         check({e.name, " bp ready"}, 64'(oReady),                 64'd0);
         check({e.name, " bp hold"},  64'({oData, oZero, oIllegal}), 64'({d0, z0, i0}));
      end
      iReady = 1'b1;
      @(posedge iClk);
      #1;
      check({e.name, " consumed"},   64'(oValid), 64'd0);
      check({e.name, " ready back"}, 64'(oReady), 64'd1);
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2:0] f3, input logic [6:0] f7, input string name);
      issue(a, b, f3, f7, name);
      collect(0, 0, 1'b0);
   endtask

   logic [9:0] legal [10] = '{
      {F7_BASE, F3_ADD}, {F7_ALT, F3_ADD}, {F7_BASE, F3_SLL}, {F7_BASE, F3_SR},
      {F7_ALT, F3_SR}, {F7_BASE, F3_SLT}, {F7_BASE, F3_SLTU}, {F7_BASE, F3_XOR},
      {F7_BASE, F3_OR}, {F7_BASE, F3_AND}};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [9:0] sel;
      iRstN = 1'b0; iValid = 1'b0; iReady = 1'b1;
      iDataA = '0; iDataB = '0; iFunct3 = '0; iFunct7 = '0;
      repeat (3) @(posedge iClk);
      #1;
      check("reset ready",   64'(oReady),   64'd1);
      check("reset valid",   64'(oValid),   64'd0);
      check("reset data",    64'(oData),    64'd0);
      check("reset zero",    64'(oZero),    64'd1);
      check("reset illegal", 64'(oIllegal), 64'd0);
      @(negedge iClk);
      iRstN = 1'b1;

      op(32'h7FFF_FFFF, 32'h1,        F3_ADD,  F7_BASE, "add_ovf");
      op(32'd5,         32'd5,        F3_ADD,  F7_ALT,  "sub_zero");
      op(32'h0,         32'h1,        F3_ADD,  F7_ALT,  "sub_wrap");
      op(32'hFFFF_FFFF, 32'h1,        F3_SLT,  F7_BASE, "slt_neg");
      op(32'hFFFF_FFFF, 32'h1,        F3_SLTU, F7_BASE, "sltu_big");
      op(32'h8000_0000, 32'h7FFF_FFFF, F3_SLT, F7_BASE, "slt_ovf");
      op(32'h8000_0000, 32'd31,       F3_SR,   F7_ALT,  "sra31");
      op(32'h8000_0000, 32'd31,       F3_SR,   F7_BASE, "srl31");
      op(32'h8000_0000, 32'h20,       F3_SLL,  F7_BASE, "sll_amt0");
      op(32'h0000_0001, 32'hFFFF_FFE1, F3_SLL, F7_BASE, "sll_upperB");
      op(32'hF0F0_1234, 32'h0FF0_FFFF, F3_AND, F7_BASE, "and");
      op(32'hF0F0_0000, 32'h0000_0F0F, F3_OR,  F7_BASE, "or");
      op(32'h1234_5678, 32'h9,        F3_SLL,  F7_ALT,  "illegal_alt");
      op(32'h1234_5678, 32'h9,        F3_XOR,  F7_MULDIV, "illegal_md");
      op(32'h0000_FFFF, 32'h0001_0001, F3_ADD, F7_MULDIV, "mul");

      // Back-pressure with iValid pulsed both while shifting and while holding.
      iReady = 1'b0;
      issue(32'hC000_0000, 32'd4, F3_SR, F7_ALT, "bp_sra4");
      iDataA = 32'h1; iDataB = 32'h1; iFunct3 = F3_ADD; iFunct7 = F7_BASE; iValid = 1'b1;
      @(posedge iClk);
      #1;
      iValid = 1'b0;
      collect(1, 5, 1'b1);
      repeat (3) @(posedge iClk);
      #1;
      check("bp no extra result", 64'(oValid), 64'd0);
      check("bp idle",            64'(oReady), 64'd1);

      for (int n = 0; n < 16; n++) begin
         sel = legal[$urandom_range(0, 9)];
         op($urandom, $urandom, sel[2:0], sel[9:3], $sformatf("rand%0d", n));
      end

      // Reset in the middle of a 31-bit shift discards the operation.
      drive(32'h8000_0000, 32'd31, F3_SR, F7_BASE, "rst_shift");
      repeat (9) @(posedge iClk);
      #3;
      iRstN = 1'b0;
      #1;
      check("midrst ready",   64'(oReady),   64'd1);
      check("midrst valid",   64'(oValid),   64'd0);
      check("midrst data",    64'(oData),    64'd0);
      check("midrst zero",    64'(oZero),    64'd1);
      check("midrst illegal", 64'(oIllegal), 64'd0);
      @(negedge iClk);
      iRstN = 1'b1;
      repeat (35) @(posedge iClk);
      #1;
      check("midrst no result", 64'(oValid), 64'd0);
      op(32'h0000_F0F0, 32'h0000_0FF0, F3_XOR, F7_BASE, "xor_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle, width-parametrised successor to the single-cycle datapath ALU. It executes the RV32 R-type integer operation set selected by funct3/funct7 behind a valid/ready handshake on both input and output. Shifts iterate one bit per cycle and the optional multiply uses shift-add. It sits between the register-read stage and writeback and stalls the pipeline through `oReady`/`oValid`.

## Interface
- `WIDTH`, default 32: operand and result width; must be a power of two and at least 8.
- `SHW`, default $clog2(WIDTH): shift-amount width (derived; do not override).
- `iClk`  in  1  clock; all state updates on the rising edge.
- `iRstN`  in  1  asynchronous, active-low reset.
- `iValid`  in  1  request valid.
- `oReady`  out  1  high only in IDLE; a request is accepted on the edge where `iValid && oReady`.
- `iDataA`, `iDataB`  in  WIDTH  operands.
- `iFunct3`  in  3  operation select.
- `iFunct7`  in  7  operation modifier.
- `oValid`  out  1  result valid; held until it is consumed.
- `iReady`  in  1  consumer ready; the result is consumed on the edge where `oValid && iReady`.
- `oData`  out  WIDTH  registered result.
- `oZero`  out  1  registered; high when `oData == 0`.
- `oIllegal`  out  1  registered; high when the funct3/funct7 pair is unsupported.

## Operation
- Operands and selects are latched on accept; later changes to the inputs have no effect on the operation in flight.
- States:
  - IDLE: on accept, go to EXEC1, SHIFT or MUL according to the operation.
  - EXEC1: single-cycle result is written; go to DONE.
  - SHIFT: one bit per cycle; go to DONE when the count reaches 0.
  - MUL: WIDTH iterations; go to DONE when they finish.
  - DONE: hold the result until it is consumed, then go to IDLE.
- Operations as funct7/funct3:
  - 0000000/000 ADD; 0100000/000 SUB.
  - 0000000/001 SLL; 0000000/101 SRL; 0100000/101 SRA.
  - 0000000/010 SLT (signed); 0000000/011 SLTU.
  - 0000000/100 XOR; 0000000/110 OR; 0000000/111 AND.
  - 0000001/000 MUL: low WIDTH bits of the product, only when the macro in Configuration is defined.
- Arithmetic rule: every datapath function is built from gate-level logic. No `+ - * / << >> <<< >>>` operators in the datapath. The only exception is the SHW-bit iteration counter, which uses a gate-level decrementer.
- ADD/SUB: shared carry-lookahead adder. SUB is A + ~B + 1. Overflow wraps modulo 2^WIDTH.
- SLT: sign of A−B corrected by overflow. SLTU: inverted carry-out of A−B. Result is 0 or 1, zero-extended.
- Shift amount is `iDataB[SHW-1:0]`; upper bits of B are ignored.
  - Each SHIFT cycle moves one bit.
  - SRA replicates the sign bit.
  - A shift amount of 0 is routed to EXEC1 and returns A unchanged.
- MUL: multiplicand shifts left by one wire-permutation each cycle; the multiplier is scanned from its LSB; the partial sum accumulates through the CLA.
- Unsupported funct3/funct7 pair: EXEC1 path, `oData = 0`, `oZero = 1`, `oIllegal = 1`.
- Output registers change only on the transition into DONE.

## Timing
- Reset values: state IDLE, `oReady = 1`, `oValid = 0`, `oData = 0`, `oZero = 1`, `oIllegal = 0`, internal counter 0.
- Latency is counted from the accept edge to the first cycle with `oValid` high:
  - ADD/SUB/logic/compare/illegal, and shifts by 0: 1 cycle.
  - Shift by k (1 ≤ k ≤ WIDTH−1): 1+k cycles.
  - MUL: WIDTH+1 cycles.
- Back-pressure: while `iReady` is low, `oData`, `oZero` and `oIllegal` stay frozen and `oValid` stays high.
- Consume edge: `oValid` drops on the following cycle. `oReady` rises in that same cycle, so there is one idle cycle between results.
- `iValid` while busy: ignored. The requester must hold its request until `oReady` is high.
- `iRstN` asserted mid-operation: immediately forces the reset values and discards the operation in flight, with no result and no partial output.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - MUL state, multiplier shift register and accumulator are compiled in.
  - funct7 0000001 / funct3 000 is legal.
- `ALU_SEQ_MUL_EN` undefined:
  - MUL logic is absent.
  - That encoding is treated as illegal: 1-cycle latency, `oIllegal = 1`, `oData = 0`.

## Structure
- Shared package `alu_pkg`:
  - FSM state enumeration.
  - funct3 constants: F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND.
  - funct7 constants: F7_BASE = 0000000, F7_ALT = 0100000, F7_MULDIV = 0000001.
- Sub-module `cla_adder`:
  - Parametrised WIDTH; 4-bit lookahead groups with a ripple of group carries.
  - Ports: A, B, carry-in; outputs sum and carry-out.
  - One instance, shared by ADD, SUB, SLT, SLTU and MUL.

## Test plan
- Reset then ADD: A=0x7FFFFFFF, B=1 → `oData` 0x80000000, `oZero` 0, `oValid` 1 cycle after accept. SUB 5−5 → `oData` 0, `oZero` 1.
- Compares: A=0xFFFFFFFF, B=1. SLT → 1; SLTU → 0.
- Shifts with A=0x80000000, shift amount 31 → `oValid` 32 cycles after accept:
  - SRA → 0xFFFFFFFF; SRL → 0x00000001.
  - SLL with B=0x20 (shift amount 0) → A unchanged, 1-cycle latency.
- Back-pressure: hold `iReady` low 5 cycles after `oValid` → output stable. `iValid` pulsed during busy is not accepted; `oReady` rises the cycle after consume.
- MUL with macro defined: 0xFFFF × 0x10001 → 0xFFFFFFFF after 33 cycles. Macro undefined: same request → `oIllegal` 1, `oData` 0, 1 cycle.
- Drop `iRstN` in cycle 10 of a 31-bit shift → outputs return to reset values at once. After release, a new XOR 0xF0F0 ^ 0x0FF0 → 0xFF00.
